// File: rtl/mem_responder.sv
// Word-addressed 32-bit memory responder with a request/complete handshake.
// Optional wait states are compiled in with the MEM_WAIT_STATE_EN macro.
module mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2 + 2;

`ifdef MEM_WAIT_STATE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
`endif

  logic [31:0]           r_mem [DEPTH];
  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic                  w_perform;
  logic [AW-1:0]         w_p_adr;
  logic [31:0]           w_p_wdata;
  logic                  w_p_rd;
  logic                  w_p_wr;
  logic                  w_err;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_unused;

  // Address bits above the array index wrap and are intentionally dropped.
  assign w_unused = ^Adr[31:AW];

`ifdef MEM_WAIT_STATE_EN
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic          w_accept;
  logic [AW-1:0] r_adr;
  logic [31:0]   r_wdata;
  logic          r_rd;
  logic          r_wr;

  assign w_p_adr   = r_adr;
  assign w_p_wdata = r_wdata;
  assign w_p_rd    = r_rd;
  assign w_p_wr    = r_wr;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_perform   = 1'b0;
    case (r_state)
      IDLE: begin
        if (MemRead || MemWrite) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT;
          w_cnt_nxt   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_perform   = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Request capture is pure data; it is only consumed after an accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_adr   <= Adr[AW-1:0];
      r_wdata <= WriteData;
      r_rd    <= MemRead;
      r_wr    <= MemWrite;
    end
  end
`else
  // Without wait states the accept edge is also the perform edge.
  assign w_p_adr   = Adr[AW-1:0];
  assign w_p_wdata = WriteData;
  assign w_p_rd    = MemRead;
  assign w_p_wr    = MemWrite;

  always_comb begin
    w_state_nxt = r_state;
    w_perform   = 1'b0;
    case (r_state)
      IDLE: begin
        if (MemRead || MemWrite) begin
          w_perform   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
`endif

  assign w_err = (w_p_adr[1:0] != 2'b00) || (w_p_rd && w_p_wr);
  assign w_idx = w_p_adr[AW-1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_perform) begin
        r_err <= w_err;
        if (!w_err && w_p_rd) begin
          r_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  // Memory survives reset, but a reset on the perform edge cancels the store.
  always_ff @(posedge clk) begin
    if (w_perform && !rst && !w_err && w_p_wr) begin
      r_mem[w_idx] <= w_p_wdata;
    end
  end

  assign ReadData = r_rdata;
  assign MemReady = (r_state == RESP);
  assign MemErr   = (r_state == RESP) && r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder; adapts expected latency
// to whether MEM_WAIT_STATE_EN is defined.
module tb_mem_responder;

  localparam int LAT = 2;
`ifdef MEM_WAIT_STATE_EN
  localparam int EXP_I = LAT + 1;
`else
  localparam int EXP_I = 1;
`endif
  localparam int PERIOD = EXP_I + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemErr;

  int checks   = 0;
  int failures = 0;

  mem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .Adr(Adr), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .ReadData(ReadData), .MemReady(MemReady), .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v);
    int lat;
    lat = 0;
    @(negedge clk);
    MemRead   = v.rd;
    MemWrite  = v.wr;
    Adr       = v.adr;
    WriteData = v.wdata;
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (MemReady === 1'b1) lat = i;
    end
    check("latency", 32'(lat), 32'(EXP_I));
    check("err", {31'd0, MemErr}, {31'd0, v.exp_err});
    check("rdata", ReadData, v.exp_rdata);
    @(negedge clk);
    check("pulse_end", {30'd0, MemReady, MemErr}, 32'd0);
  endtask

  initial begin
    int pulses;
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h1234_5678};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 1'b1, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0032, 32'h1111_1111, 1'b1, 32'hCAFE_F00D};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0030, 32'h0BAD_C0DE, 1'b0, 32'hCAFE_F00D};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0,         1'b0, 32'h0BAD_C0DE};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h8765_4321, 1'b0, 32'h0BAD_C0DE};
    vecs[13] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b0, 32'h8765_4321};

    rst = 1'b1; Adr = 32'd0; WriteData = 32'd0; MemRead = 1'b0; MemWrite = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_rdata", ReadData, 32'd0);
    check("reset_flags", {30'd0, MemReady, MemErr}, 32'd0);

    for (int k = 0; k < 14; k++) do_txn(vecs[k]);

    // Reset racing a write of 0xA5A5A5A5 to 0x30 must cancel it.
    @(negedge clk);
    MemWrite = 1'b1; Adr = 32'h30; WriteData = 32'hA5A5_A5A5;
`ifdef MEM_WAIT_STATE_EN
    @(posedge clk);
    @(negedge clk);
    MemWrite = 1'b0;
    check("no_ready_in_wait", {31'd0, MemReady}, 32'd0);
    rst = 1'b1;
`else
    rst = 1'b1;
`endif
    @(posedge clk);
    @(negedge clk);
    MemWrite = 1'b0;
    rst = 1'b0;
    check("rst_rdata", ReadData, 32'd0);
    check("rst_flags", {30'd0, MemReady, MemErr}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (MemReady !== 1'b0) pulses++;
    end
    check("rst_no_pulse", 32'(pulses), 32'd0);
    do_txn('{1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0BAD_C0DE});

    // Request held high is re-accepted on the first IDLE edge after RESP.
    do_txn('{1'b0, 1'b1, 32'h44, 32'h5555_AAAA, 1'b0, 32'h0BAD_C0DE});
    @(negedge clk);
    MemRead = 1'b1; Adr = 32'h44;
    pulses = 0;
    for (int i = 1; i <= EXP_I + PERIOD; i++) begin
      @(negedge clk);
      check($sformatf("held_ready_%0d", i), {31'd0, MemReady},
            {31'd0, (i == EXP_I) || (i == EXP_I + PERIOD)});
    end
    MemRead = 1'b0;
    check("held_rdata", ReadData, 32'h5555_AAAA);
    @(negedge clk);
    @(negedge clk);
    check("held_idle", {30'd0, MemReady, MemErr}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the word count (256 x 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the wait cycles when wait states are compiled in; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port Adr, input, 32 bits: byte address of the request.
REQ-006 SHALL have port WriteData, input, 32 bits: store data.
REQ-007 SHALL have port MemRead, input, 1 bit: read request (level).
REQ-008 SHALL have port MemWrite, input, 1 bit: write request (level).
REQ-009 SHALL have port ReadData, output, 32 bits: registered load data, held until the next completed read.
REQ-010 SHALL have port MemReady, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port MemErr, output, 1 bit: error flag; valid only while MemReady=1.

Function
REQ-012 SHALL store 2^DEPTH_LOG2 words, indexed by Adr[DEPTH_LOG2+1:2]; higher Adr bits SHALL be ignored (address wrap).
REQ-013 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-014 In IDLE, a rising edge with MemRead|MemWrite=1 SHALL accept the request and capture Adr, WriteData and the operation.
REQ-015 Request inputs SHALL be ignored in WAIT and RESP.
REQ-016 On accept, the FSM SHALL go to WAIT and load the 4-bit counter with LATENCY-1.
REQ-017 In WAIT, a counter value of 0 at an edge SHALL perform the access and go to RESP; otherwise the counter SHALL decrement.
REQ-018 RESP SHALL last exactly one cycle with MemReady=1, then return to IDLE.
REQ-019 MemReady SHALL be 0 in every other state.
REQ-020 A request held high through RESP SHALL be accepted again as a new transaction at the first IDLE edge.
REQ-021 For a write, the captured word SHALL commit at the perform edge; ReadData SHALL be unchanged.
REQ-022 For a read, ReadData SHALL load mem[index] at the perform edge.
REQ-023 A captured Adr[1:0]!=0 SHALL suppress the access, leave ReadData and memory unchanged, and set MemErr=1 during RESP.
REQ-024 MemRead=1 and MemWrite=1 on the same accept edge SHALL suppress the access and set MemErr=1 during RESP.
REQ-025 MemErr SHALL be 0 whenever MemReady=0.

Reset
REQ-026 When rst=1 at an edge, the block SHALL go to IDLE with counter=0, MemReady=0, MemErr=0 and ReadData=0; rst SHALL take priority over any accept.
REQ-027 Reset during WAIT SHALL discard the pending transaction: no write commits and no MemReady pulse.
REQ-028 Reset SHALL NOT clear memory contents.

Configuration
REQ-029 SHALL support the macro MEM_WAIT_STATE_EN.
REQ-030 With MEM_WAIT_STATE_EN defined, the block SHALL behave per REQ-016..REQ-018: MemReady rises LATENCY edges after the accept edge.
REQ-031 Without MEM_WAIT_STATE_EN, WAIT and the counter SHALL be absent: the accept edge performs the access and enters RESP, so MemReady is high in the cycle right after the accept edge; LATENCY is ignored.

Verification
REQ-032 Macro on, LATENCY=2: write 0xDEADBEEF to Adr 0x10 at edge 0 -> MemReady=1 after edge 2 only, MemErr=0; then read Adr 0x10 -> ReadData=0xDEADBEEF with MemReady after edge 2 of that transaction.
REQ-033 Write 0x12345678 to Adr 0x400 (DEPTH_LOG2=8), then read Adr 0x0 -> ReadData=0x12345678 (wrap).
REQ-034 Read Adr 0x13 -> MemReady pulse with MemErr=1; ReadData keeps its previous value; the word at 0x10 is unchanged.
REQ-035 MemRead=MemWrite=1, Adr 0x20, WriteData 0xFFFFFFFF -> MemErr=1; a later read of 0x20 returns the prior contents.
REQ-036 Write 0xA5A5A5A5 to 0x30 and assert rst one edge after accept -> no MemReady pulse; a subsequent read of 0x30 returns the old value; outputs are 0 after reset.
REQ-037 Macro off: read request at edge 0 -> MemReady=1 after edge 0; the request held high is re-accepted at edge 2.
